md5_req_sched: RTL

Shares one pancham MD5 core between N_REQ independent requesters. Each requester presents a single-block message. The scheduler picks requesters round-robin, issues one job at a time to the core, and waits for the digest with a watchdog. It returns the digest on a shared response bus tagged with the requester id. It sits between the requester ports and the pancham instance and owns the core's msg_in_valid handshake.

---
 rtl/md5_sched_pkg.sv | 22 ++
 rtl/md5_req_sched_if.sv | 46 ++++
 rtl/rr_pick.sv | 33 +++
 rtl/md5_req_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/md5_sched_pkg.sv
// Shared widths, limits and FSM state type for the MD5 request scheduler.
package md5_sched_pkg;

  localparam int unsigned MSG_W    = 128;
  localparam int unsigned WIDTH_W  = 8;
  localparam int unsigned DIGEST_W = 128;

  localparam logic [WIDTH_W-1:0] MAX_MSG_BITS = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  // A job the core cannot take: empty or longer than one block.
  function automatic logic width_bad(input logic [WIDTH_W-1:0] w);
    return (w == '0) || (w > MAX_MSG_BITS);
  endfunction

endpackage

// File: rtl/md5_req_sched_if.sv
// Requester, core and response signals of the MD5 scheduler.
interface md5_req_sched_if
  import md5_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*MSG_W-1:0]   req_msg;
  logic [N_REQ*WIDTH_W-1:0] req_width;
  logic [N_REQ-1:0]         req_ack;

  logic [MSG_W-1:0]    core_msg_in;
  logic [WIDTH_W-1:0]  core_msg_in_width;
  logic                core_msg_in_valid;
  logic [DIGEST_W-1:0] core_msg_output;
  logic                core_msg_out_valid;
  logic                core_ready;

  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [DIGEST_W-1:0] resp_digest;
  logic                resp_err;
  logic                busy;

  // Scheduler side.
  modport master (
    input  req_valid, req_msg, req_width,
    input  core_msg_output, core_msg_out_valid, core_ready,
    output req_ack,
    output core_msg_in, core_msg_in_width, core_msg_in_valid,
    output resp_valid, resp_id, resp_digest, resp_err, busy
  );

  // Requesters, core and response consumer.
  modport slave (
    output req_valid, req_msg, req_width,
    output core_msg_output, core_msg_out_valid, core_ready,
    input  req_ack,
    input  core_msg_in, core_msg_in_width, core_msg_in_valid,
    input  resp_valid, resp_id, resp_digest, resp_err, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           gnt_any_o,
  output logic [IDW-1:0] gnt_id_o
);

  localparam int unsigned SW = IDW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  off;
  logic [SW-1:0]  sum;

  always_comb begin
    // Doubling the vector turns the wrap-around search into a plain slice.
    dbl = {req_i, req_i};
    rot = dbl[ptr_i +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_any_o = |req_i;
    gnt_id_o  = sum[IDW-1:0];
  end

endmodule

// File: rtl/md5_req_sched.sv
// Round-robin scheduler sharing one MD5 core between N_REQ single-block requesters.
module md5_req_sched
  import md5_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  md5_req_sched_if.master bus
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  sched_state_e        state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                err_q, err_d;
  logic                in_valid_q, in_valid_d;
  logic                resp_valid_q, resp_valid_d;
  logic                busy_q, busy_d;

  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic               grant;
  logic [WIDTH_W-1:0] gnt_width;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

  // The ack must land in the grant cycle, so it is decoded rather than registered.
  assign grant     = !reset && (state_q == IDLE) && bus.core_ready && gnt_any;
  assign gnt_width = bus.req_width[gnt_id*WIDTH_W +: WIDTH_W];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    timer_d  = timer_q;
    msg_d    = msg_q;
    width_d  = width_q;
    digest_d = digest_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          msg_d    = bus.req_msg[gnt_id*MSG_W +: MSG_W];
          width_d  = gnt_width;
          id_d     = gnt_id;
          digest_d = '0;
          err_d    = width_bad(gnt_width);
          state_d  = width_bad(gnt_width) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // A digest arriving on the expiry cycle still counts as success.
        if (bus.core_msg_out_valid) begin
          digest_d = bus.core_msg_output;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          digest_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_valid_d   = (state_d == ISSUE);
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      timer_q      <= '0;
      msg_q        <= '0;
      width_q      <= '0;
      digest_q     <= '0;
      err_q        <= 1'b0;
      in_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      msg_q        <= msg_d;
      width_q      <= width_d;
      digest_q     <= digest_d;
      err_q        <= err_d;
      in_valid_q   <= in_valid_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ack           = grant ? (N_REQ'(1) << gnt_id) : '0;
  assign bus.core_msg_in       = msg_q;
  assign bus.core_msg_in_width = width_q;
  assign bus.core_msg_in_valid = in_valid_q;
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_id           = id_q;
  assign bus.resp_digest       = digest_q;
  assign bus.resp_err          = err_q;
  assign bus.busy              = busy_q;

endmodule
